// File: rtl/wb_pkg.sv
// Shared types and default configuration for the write-back arbiter.
// Optional feature: WB_ARBITER_PEND_EN (pending-write probe in wb_queue).
package wb_pkg;

    // Default register-index width, data width and load-return queue depth.
    localparam int WB_ADDRESS_WIDTH = 5;
    localparam int WB_DATA_WIDTH    = 32;
    localparam int WB_QUEUE_DEPTH   = 4;

    // One pending register-file write: destination index and data.
    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_entry_t;

    // Issue source selected for the register-file write port in a cycle.
    typedef enum logic [1:0] {
        ISSUE_NONE  = 2'd0,
        ISSUE_ALU   = 2'd1,
        ISSUE_QUEUE = 2'd2
    } wb_issue_src_t;

endpackage : wb_pkg

// File: rtl/wb_queue.sv
// Load-return FIFO: storage, wrapping pointers, occupancy count and flush.
// With WB_ARBITER_PEND_EN defined it also reports whether a probed register
// index has a queued write and returns the youngest matching data.
// QUEUE_DEPTH must be a power of two and at least 2 so that the pointers
// wrap naturally at their width.
module wb_queue
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int QUEUE_DEPTH   = WB_QUEUE_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [ADDRESS_WIDTH-1:0] push_rd_i,
    input  logic [DATA_WIDTH-1:0]    push_data_i,
    input  logic                     pop_i,
    output logic [ADDRESS_WIDTH-1:0] head_rd_o,
    output logic [DATA_WIDTH-1:0]    head_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    input  logic [ADDRESS_WIDTH-1:0] chk_addr_i,
    output logic                     pend_hit_o,
    output logic [DATA_WIDTH-1:0]    pend_data_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDRESS_WIDTH-1:0] rd_mem   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic                     push_ok;
    logic                     pop_ok;

    assign full_o  = (count == CNT_W'(QUEUE_DEPTH));
    assign empty_o = (count == '0);

    // Internal guards keep the queue from overflowing or underflowing even
    // if a caller asserts push/pop at the wrong time.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    assign head_rd_o   = rd_mem[rd_ptr];
    assign head_data_o = data_mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset outranks flush.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage write.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array has no reset; an entry is only ever read
        // while the count covers it, so its power-up contents never matter.
        if (push_ok) begin
            rd_mem[wr_ptr]   <= push_rd_i;
            data_mem[wr_ptr] <= push_data_i;
        end
    end

`ifdef WB_ARBITER_PEND_EN
    logic [PTR_W-1:0] scan_idx;

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        pend_hit_o  = 1'b0;
        pend_data_o = '0;
        scan_idx    = rd_ptr;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (chk_addr_i != '0) &&
                (rd_mem[scan_idx] == chk_addr_i)) begin
                pend_hit_o  = 1'b1;
                pend_data_o = data_mem[scan_idx];
            end
        end
    end
`else
    logic unused_chk;

    assign pend_hit_o  = 1'b0;
    assign pend_data_o = '0;
    assign unused_chk  = ^chk_addr_i;
`endif

endmodule : wb_queue

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU/CSR results and queued load returns onto a
// single registered register-file write port. ALU results win; the queue head
// issues when no ALU result is accepted, which includes every cycle in which
// the queue is full (the ALU is then held upstream).
// Optional feature: WB_ARBITER_PEND_EN enables the pending-write probe.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int QUEUE_DEPTH   = WB_QUEUE_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    output logic                     alu_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0]    alu_data_i,
    input  logic                     ld_valid_i,
    output logic                     ld_ready_o,
    input  logic [ADDRESS_WIDTH-1:0] ld_rd_i,
    input  logic [DATA_WIDTH-1:0]    ld_data_i,
    input  logic                     flush_i,
    output logic                     rf_we_o,
    output logic [ADDRESS_WIDTH-1:0] rf_addr_o,
    output logic [DATA_WIDTH-1:0]    rf_wd_o,
    output logic                     busy_o,
    input  logic [ADDRESS_WIDTH-1:0] chk_addr_i,
    output logic                     pend_hit_o,
    output logic [DATA_WIDTH-1:0]    pend_data_o
);

    logic                     q_full;
    logic                     q_empty;
    logic [ADDRESS_WIDTH-1:0] q_head_rd;
    logic [DATA_WIDTH-1:0]    q_head_data;
    logic                     q_push;
    logic                     q_pop;

    wb_issue_src_t            issue_src;
    logic [ADDRESS_WIDTH-1:0] issue_rd;
    logic [DATA_WIDTH-1:0]    issue_data;

    // Both ready signals come from the registered count only, so a dequeue
    // never opens space in the same cycle.
    assign alu_ready_o = !q_full;
    assign ld_ready_o  = !q_full;
    assign busy_o      = !q_empty;

    assign q_push = ld_valid_i && !q_full && !flush_i;
    assign q_pop  = (issue_src == ISSUE_QUEUE);

    wb_queue #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .QUEUE_DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (q_push),
        .push_rd_i   (ld_rd_i),
        .push_data_i (ld_data_i),
        .pop_i       (q_pop),
        .head_rd_o   (q_head_rd),
        .head_data_o (q_head_data),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .chk_addr_i  (chk_addr_i),
        .pend_hit_o  (pend_hit_o),
        .pend_data_o (pend_data_o)
    );

    // Pick this cycle's issue: accepted ALU result, else queue head unless
    // a flush is discarding the queue, else nothing.
    always_comb begin
        issue_src  = ISSUE_NONE;
        issue_rd   = '0;
        issue_data = '0;
        if (alu_valid_i && !q_full) begin
            issue_src  = ISSUE_ALU;
            issue_rd   = alu_rd_i;
            issue_data = alu_data_i;
        end else if (!q_empty && !flush_i) begin
            issue_src  = ISSUE_QUEUE;
            issue_rd   = q_head_rd;
            issue_data = q_head_data;
        end
    end

    // Register the write port; writes to x0 are consumed without enabling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_wd_o   <= '0;
        end else if (issue_src != ISSUE_NONE) begin
            rf_we_o   <= (issue_rd != '0);
            rf_addr_o <= issue_rd;
            rf_wd_o   <= issue_data;
        end else begin
            rf_we_o   <= 1'b0;
        end
    end

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter (default parameters). Pending-probe
// checks are compiled in when WB_ARBITER_PEND_EN is defined; otherwise the
// probe outputs are checked to be tied to zero.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        flush_i;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_wd_o;
    logic        busy_o;
    logic [4:0]  chk_addr_i;
    logic        pend_hit_o;
    logic [31:0] pend_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alu_valid_i (alu_valid_i),
        .alu_ready_o (alu_ready_o),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_rd_i     (ld_rd_i),
        .ld_data_i   (ld_data_i),
        .flush_i     (flush_i),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
        .rf_wd_o     (rf_wd_o),
        .busy_o      (busy_o),
        .chk_addr_i  (chk_addr_i),
        .pend_hit_o  (pend_hit_o),
        .pend_data_o (pend_data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i       = 1'b1;
        alu_valid_i = 1'b0;
        alu_rd_i    = '0;
        alu_data_i  = '0;
        ld_valid_i  = 1'b0;
        ld_rd_i     = '0;
        ld_data_i   = '0;
        flush_i     = 1'b0;
        chk_addr_i  = '0;

        // Reset state
        tick();
        tick();
        check("rst_we",   rf_we_o,   0);
        check("rst_addr", rf_addr_o, 0);
        check("rst_wd",   rf_wd_o,   0);
        check("rst_busy", busy_o,    0);
        rst_i = 1'b0;
        tick();
        check("post_rst_ld_ready",  ld_ready_o,  1);
        check("post_rst_alu_ready", alu_ready_o, 1);
        check("post_rst_we",        rf_we_o,     0);

        // Single load: enqueue edge, then issue edge
        ld_valid_i = 1'b1; ld_rd_i = 5'd5; ld_data_i = 32'hDEAD_BEEF;
        tick();
        ld_valid_i = 1'b0;
        check("ld1_busy_after_enq", busy_o,  1);
        check("ld1_no_write_yet",   rf_we_o, 0);
        tick();
        check("ld1_we",   rf_we_o,   1);
        check("ld1_addr", rf_addr_o, 5);
        check("ld1_wd",   rf_wd_o,   32'hDEAD_BEEF);
        check("ld1_busy_drained", busy_o, 0);
        tick();
        check("idle_we",        rf_we_o,   0);
        check("idle_addr_hold", rf_addr_o, 5);
        check("idle_wd_hold",   rf_wd_o,   32'hDEAD_BEEF);

        // ALU and load together from empty: ALU first, load next cycle
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h11;
        ld_valid_i  = 1'b1; ld_rd_i  = 5'd4; ld_data_i  = 32'h22;
        tick();
        alu_valid_i = 1'b0; ld_valid_i = 1'b0;
        check("both_first_we",   rf_we_o,   1);
        check("both_first_addr", rf_addr_o, 3);
        check("both_first_wd",   rf_wd_o,   32'h11);
        tick();
        check("both_second_we",   rf_we_o,   1);
        check("both_second_addr", rf_addr_o, 4);
        check("both_second_wd",   rf_wd_o,   32'h22);
        tick();
        check("both_idle_we", rf_we_o, 0);

        // ALU write to x0 is accepted but never enables the write port
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'hFF;
        #1;
        check("x0_alu_ready", alu_ready_o, 1);
        tick();
        alu_valid_i = 1'b0;
        check("x0_we", rf_we_o, 0);

        // Fill the queue while the ALU hogs the port, then drain in order
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'h100;
        for (int i = 0; i < 4; i++) begin
            ld_valid_i = 1'b1; ld_rd_i = 5'(10 + i); ld_data_i = 32'h200 + 32'(i);
            tick();
        end
        ld_valid_i = 1'b0;
        check("full_ld_ready",  ld_ready_o,  0);
        check("full_alu_ready", alu_ready_o, 0);
        check("full_busy",      busy_o,      1);
        check("full_last_addr", rf_addr_o,   1);
        tick();
        check("full_head_addr", rf_addr_o,   10);
        check("full_head_wd",   rf_wd_o,     32'h200);
        check("full_ready_back", alu_ready_o, 1);
        tick();
        alu_valid_i = 1'b0;
        check("full_alu_resumes_addr", rf_addr_o, 1);
        check("full_alu_resumes_wd",   rf_wd_o,   32'h100);
        tick();
        check("drain_11_addr", rf_addr_o, 11);
        check("drain_11_wd",   rf_wd_o,   32'h201);
        tick();
        check("drain_12_addr", rf_addr_o, 12);
        check("drain_12_wd",   rf_wd_o,   32'h202);
        tick();
        check("drain_13_addr", rf_addr_o, 13);
        check("drain_13_wd",   rf_wd_o,   32'h203);
        check("drain_13_we",   rf_we_o,   1);
        check("drain_busy",    busy_o,    0);
        tick();
        check("drain_idle_we", rf_we_o, 0);

        // Queue 3 entries behind x0 ALU writes, then flush with a load present
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            ld_valid_i = 1'b1; ld_rd_i = 5'(20 + i); ld_data_i = 32'h300 + 32'(i);
            tick();
        end
        alu_valid_i = 1'b0;
        check("preflush_busy", busy_o, 1);
        flush_i = 1'b1; ld_valid_i = 1'b1; ld_rd_i = 5'd25; ld_data_i = 32'h399;
        tick();
        flush_i = 1'b0; ld_valid_i = 1'b0;
        check("flush_busy",     busy_o,     0);
        check("flush_ld_ready", ld_ready_o, 1);
        check("flush_we",       rf_we_o,    0);
        tick();
        check("flush_no_late_write", rf_we_o, 0);
        check("flush_stays_empty",   busy_o,  0);

        // Two writes to r7 held in the queue, then probe
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h0;
        ld_valid_i  = 1'b1; ld_rd_i  = 5'd7; ld_data_i  = 32'hA;
        tick();
        ld_data_i = 32'hB;
        tick();
        ld_valid_i = 1'b0;
        chk_addr_i = 5'd7;
        #1;
`ifdef WB_ARBITER_PEND_EN
        check("pend7_hit",  pend_hit_o,  1);
        check("pend7_data", pend_data_o, 32'hB);
        chk_addr_i = 5'd0;
        #1;
        check("pend0_hit", pend_hit_o, 0);
        chk_addr_i = 5'd8;
        #1;
        check("pend8_hit", pend_hit_o, 0);
`else
        check("pend_off_hit",  pend_hit_o,  0);
        check("pend_off_data", pend_data_o, 0);
`endif
        chk_addr_i = 5'd0;

        // Reset together with flush while the queue starts draining
        alu_valid_i = 1'b0;
        rst_i = 1'b1; flush_i = 1'b1;
        tick();
        rst_i = 1'b0; flush_i = 1'b0;
        check("rst_drain_we",   rf_we_o,   0);
        check("rst_drain_addr", rf_addr_o, 0);
        check("rst_drain_wd",   rf_wd_o,   0);
        check("rst_drain_busy", busy_o,    0);
        tick();
        check("rst_drain_no_write1", rf_we_o, 0);
        tick();
        check("rst_drain_no_write2", rf_we_o, 0);
        check("rst_drain_ready",     ld_ready_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_arbiter
